// File: rtl/banner_scroll_ctrl.sv
// Banner sequencer: decodes UART bytes into a BCD digit buffer and scroll commands, and paces the shift register.
// Define BANNER_SPEED_EN to add the '+'/'-' speed register (tick period = DIV >> speed).
`timescale 1ns/1ps
module banner_scroll_ctrl #(
   parameter int W   = 4,
   parameter int N   = 6,
   parameter int DIV = 50_000_000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   output logic [W*N-1:0]         sr_data,
   output logic                   sr_write,
   output logic                   sr_start,
   output logic                   sr_pause,
   output logic                   sr_set_left,
   output logic                   sr_set_right,
   output logic                   running,
   output logic                   dir_left,
   output logic [$clog2(N+1)-1:0] step_cnt
);
   localparam int SW = $clog2(N+1);
   localparam int PW = $clog2(DIV);
   localparam logic [SW-1:0] STEP_LAST = SW'(N);

   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_ARM, ST_STEP} state_t;

   state_t                 state_reg;
   logic                   sr_write_reg, sr_start_reg, sr_pause_reg;
   logic                   write_pend_reg;
   logic [SW-1:0]          step_cnt_reg;
   logic [N-1:0][W-1:0]    buf_reg, buf_next;
   logic                   running_reg, dir_left_reg;
   logic                   left_pend_reg, right_pend_reg;
   logic [PW-1:0]          presc_reg, term;
   logic                   tick, speed_chg;

   logic is_digit, is_start, is_stop, is_left, is_right, is_clear;
   logic sched_write, force_reload;

   assign is_digit     = rx_valid && (rx_data >= 8'h30) && (rx_data <= 8'h39);
   assign is_start     = rx_valid && (rx_data == 8'h53);
   assign is_stop      = rx_valid && (rx_data == 8'h50);
   assign is_left      = rx_valid && (rx_data == 8'h4C);
   assign is_right     = rx_valid && (rx_data == 8'h52);
   assign is_clear     = rx_valid && (rx_data == 8'h43);
   assign sched_write  = (is_digit && !running_reg) || is_clear;
   assign force_reload = is_left || is_right;

   // Digit 0 is the newest (least significant) digit of the reload image.
   genvar gi;
   for (gi = 0; gi < N; gi++) begin : g_digit
      if (gi == 0) begin : g_head
         assign buf_next[gi] = is_clear ? '0 :
                               is_digit ? rx_data[W-1:0] : buf_reg[gi];
      end else begin : g_tail
         assign buf_next[gi] = is_clear ? '0 :
                               is_digit ? buf_reg[gi-1] : buf_reg[gi];
      end
   end

`ifdef BANNER_SPEED_EN
   localparam logic [31:0] DIV_W = 32'(DIV);
   logic [1:0] speed_reg;
   logic       is_inc, is_dec;

   assign is_inc    = rx_valid && (rx_data == 8'h2B);
   assign is_dec    = rx_valid && (rx_data == 8'h2D);
   assign speed_chg = (is_inc && speed_reg != 2'd3) || (is_dec && speed_reg != 2'd0);
   assign term      = PW'((DIV_W >> speed_reg) - 32'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         speed_reg <= 2'd0;
      else if (is_inc && speed_reg != 2'd3)
         speed_reg <= speed_reg + 2'd1;
      else if (is_dec && speed_reg != 2'd0)
         speed_reg <= speed_reg - 2'd1;
   end
`else
   assign speed_chg = 1'b0;
   assign term      = PW'(DIV - 1);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         presc_reg <= '0;
      else if (speed_chg || presc_reg >= term)
         presc_reg <= '0;
      else
         presc_reg <= presc_reg + 1'b1;
   end
   assign tick = (presc_reg == term);

   // Ticks are only honoured in IDLE; a pending write always beats a tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         sr_write_reg   <= 1'b0;
         sr_start_reg   <= 1'b0;
         sr_pause_reg   <= 1'b0;
         write_pend_reg <= 1'b0;
         step_cnt_reg   <= '0;
      end else begin
         sr_write_reg <= 1'b0;
         sr_start_reg <= 1'b0;
         sr_pause_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (write_pend_reg) begin
                  state_reg      <= ST_WRITE;
                  sr_write_reg   <= 1'b1;
                  write_pend_reg <= 1'b0;
               end else if (tick && running_reg) begin
                  if (step_cnt_reg == STEP_LAST) begin
                     state_reg    <= ST_WRITE;
                     sr_write_reg <= 1'b1;
                  end else begin
                     state_reg    <= ST_ARM;
                     sr_start_reg <= 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               step_cnt_reg <= '0;
               state_reg    <= ST_IDLE;
            end
            ST_ARM: begin
               sr_pause_reg <= 1'b1;
               state_reg    <= ST_STEP;
            end
            default: begin
               step_cnt_reg <= step_cnt_reg + 1'b1;
               state_reg    <= ST_IDLE;
            end
         endcase
         if (sched_write)
            write_pend_reg <= 1'b1;
         if (force_reload)
            step_cnt_reg <= STEP_LAST;
      end
   end

   // Direction pulses wait out any load pulse; the latest L/R byte wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_reg        <= '0;
         running_reg    <= 1'b0;
         dir_left_reg   <= 1'b0;
         left_pend_reg  <= 1'b0;
         right_pend_reg <= 1'b0;
      end else begin
         buf_reg <= buf_next;
         if (is_start)
            running_reg <= 1'b1;
         else if (is_stop)
            running_reg <= 1'b0;
         if (is_left) begin
            dir_left_reg   <= 1'b1;
            left_pend_reg  <= 1'b1;
            right_pend_reg <= 1'b0;
         end else if (is_right) begin
            dir_left_reg   <= 1'b0;
            left_pend_reg  <= 1'b0;
            right_pend_reg <= 1'b1;
         end else if (!sr_write_reg) begin
            left_pend_reg  <= 1'b0;
            right_pend_reg <= 1'b0;
         end
      end
   end

   assign sr_data      = buf_reg;
   assign sr_write     = sr_write_reg;
   assign sr_start     = sr_start_reg;
   assign sr_pause     = sr_pause_reg;
   assign sr_set_left  = left_pend_reg && !sr_write_reg;
   assign sr_set_right = right_pend_reg && !sr_write_reg;
   assign running      = running_reg;
   assign dir_left     = dir_left_reg;
   assign step_cnt     = step_cnt_reg;

endmodule

// File: tb/tb_banner_scroll_ctrl.sv
// Bench for banner_scroll_ctrl: byte-decode vector table plus hand sequences for scrolling, direction, pause and reset.
`timescale 1ns/1ps
module tb_banner_scroll_ctrl;
   localparam int W = 4;
   localparam int N = 6;
`ifdef BANNER_SPEED_EN
   localparam int DIV = 8;
`else
   localparam int DIV = 4;
`endif
   localparam int SW  = $clog2(N+1);
   localparam int LIM = 2*DIV + 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [7:0]      rx_data;
   logic            rx_valid;
   logic [W*N-1:0]  sr_data;
   logic            sr_write, sr_start, sr_pause, sr_set_left, sr_set_right;
   logic            running, dir_left;
   logic [SW-1:0]   step_cnt;

   banner_scroll_ctrl #(.W(W), .N(N), .DIV(DIV)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .sr_data(sr_data), .sr_write(sr_write), .sr_start(sr_start), .sr_pause(sr_pause),
      .sr_set_left(sr_set_left), .sr_set_right(sr_set_right),
      .running(running), .dir_left(dir_left), .step_cnt(step_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int cnt_start = 0, cnt_pause = 0, cnt_write = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (sr_start) cnt_start <= cnt_start + 1;
      if (sr_pause) cnt_pause <= cnt_pause + 1;
      if (sr_write) cnt_write <= cnt_write + 1;
   end

   typedef struct packed {
      logic [7:0]  b;
      logic [3:0]  wpat;
      logic [23:0] data;
      logic        run;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic strobe(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      strobe(b);
   endtask

   function automatic logic sig(input int which);
      case (which)
         0:       return sr_start;
         1:       return sr_write;
         default: return dut.tick;
      endcase
   endfunction

   task automatic wait_sig(input int which, output logic seen);
      seen = 1'b0;
      for (int i = 0; i < LIM; i++) begin
         @(negedge clk);
         if (sig(which)) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic measure(input string name, input int exp);
      logic seen;
      int   t0;
      wait_sig(2, seen);
      t0 = cyc;
      if (seen) wait_sig(2, seen);
      check({name, " tick found"}, 32'(seen), 32'd1);
      check({name, " tick spacing"}, 32'(cyc - t0), 32'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got running bench, expected finish");
      $fatal(1);
   end

   initial begin
      logic       seen;
      logic [3:0] wpat;
      int         last, cs, cw, cp;

      vecs[0]  = '{8'h39, 4'b0010, 24'h000009, 1'b0};
      vecs[1]  = '{8'h43, 4'b0010, 24'h000000, 1'b0};
      vecs[2]  = '{8'h37, 4'b0010, 24'h000007, 1'b0};
      vecs[3]  = '{8'h41, 4'b0000, 24'h000007, 1'b0};
      vecs[4]  = '{8'h31, 4'b0010, 24'h000071, 1'b0};
      vecs[5]  = '{8'h32, 4'b0010, 24'h000712, 1'b0};
      vecs[6]  = '{8'h33, 4'b0010, 24'h007123, 1'b0};
      vecs[7]  = '{8'h34, 4'b0010, 24'h071234, 1'b0};
      vecs[8]  = '{8'h35, 4'b0010, 24'h712345, 1'b0};
      vecs[9]  = '{8'h36, 4'b0010, 24'h123456, 1'b0};
      vecs[10] = '{8'h50, 4'b0000, 24'h123456, 1'b0};

      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check("reset sr_data", 32'(sr_data), 32'd0);
      check("reset pulses", {27'd0, sr_write, sr_start, sr_pause, sr_set_left, sr_set_right}, 32'd0);
      check("reset running", 32'(running), 32'd0);
      check("reset dir_left", 32'(dir_left), 32'd0);
      check("reset step_cnt", 32'(step_cnt), 32'd0);
      reset = 1'b0;

      // Byte decode while stopped: write pulse lands on the 2nd sampled cycle after the byte.
      for (int i = 0; i < 11; i++) begin
         send_byte(vecs[i].b);
         wpat = 4'b0000;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            wpat[k] = sr_write;
         end
         check($sformatf("vec%0d write timing", i), 32'(wpat), 32'(vecs[i].wpat));
         check($sformatf("vec%0d sr_data", i), 32'(sr_data), 32'(vecs[i].data));
         check($sformatf("vec%0d running", i), 32'(running), 32'(vecs[i].run));
         check($sformatf("vec%0d step_cnt", i), 32'(step_cnt), 32'd0);
      end

      // Full scroll loop: N start/pause pairs DIV apart, then a reload.
      send_byte(8'h53);
      check("S running", 32'(running), 32'd1);
      cs = cnt_start;
      last = 0;
      for (int k = 0; k < N; k++) begin
         wait_sig(0, seen);
         check($sformatf("step%0d start found", k), 32'(seen), 32'd1);
         if (k > 0) check($sformatf("step%0d start spacing", k), 32'(cyc - last), 32'(DIV));
         last = cyc;
         @(negedge clk);
         check($sformatf("step%0d pause", k), {30'd0, sr_pause, sr_start}, 32'd2);
         @(negedge clk);
         check($sformatf("step%0d step_cnt", k), 32'(step_cnt), 32'(k + 1));
      end
      wait_sig(1, seen);
      check("reload write found", 32'(seen), 32'd1);
      check("reload spacing", 32'(cyc - last), 32'(DIV));
      check("reload sr_data", 32'(sr_data), 32'h123456);
      check("loop start count", 32'(cnt_start - cs), 32'(N));
      @(negedge clk);
      check("reload step_cnt", 32'(step_cnt), 32'd0);

      // 'L' on a STEP cycle: left pulse next cycle, next tick reloads.
      wait_sig(0, seen);
      check("L pre start found", 32'(seen), 32'd1);
      @(negedge clk);
      strobe(8'h4C);
      @(negedge clk);
      check("L set_left pulse", {30'd0, sr_set_left, sr_set_right}, 32'd2);
      check("L dir_left", 32'(dir_left), 32'd1);
      check("L step_cnt", 32'(step_cnt), 32'(N));
      @(negedge clk);
      check("L set_left single", 32'(sr_set_left), 32'd0);
      cs = cnt_start;
      wait_sig(1, seen);
      check("L reload write found", 32'(seen), 32'd1);
      check("L no start before reload", 32'(cnt_start - cs), 32'd0);
      check("L reload sr_data", 32'(sr_data), 32'h123456);

      // 'P' on the start cycle: pause still follows, then no more starts.
      wait_sig(0, seen);
      check("P start found", 32'(seen), 32'd1);
      strobe(8'h50);
      @(negedge clk);
      check("P pause follows", 32'(sr_pause), 32'd1);
      check("P running", 32'(running), 32'd0);
      cs = cnt_start;
      cw = cnt_write;
      repeat (41) @(negedge clk);
      check("P no starts", 32'(cnt_start - cs), 32'd0);
      check("P no writes", 32'(cnt_write - cw), 32'd0);

      // 'C' then 'R' back to back: right pulse deferred past the write cycle.
      send_byte(8'h43);
      send_byte(8'h52);
      @(negedge clk);
      check("CR write cycle", {30'd0, sr_write, sr_set_right}, 32'd2);
      check("CR sr_data", 32'(sr_data), 32'd0);
      check("CR dir_left", 32'(dir_left), 32'd0);
      @(negedge clk);
      check("CR deferred right", {30'd0, sr_write, sr_set_right}, 32'd1);

      // Reset during ARM kills the pending pause.
      send_byte(8'h53);
      wait_sig(0, seen);
      check("RST start found", 32'(seen), 32'd1);
      cp = cnt_pause;
      reset = 1'b1;
      #1;
      check("RST async start drop", 32'(sr_start), 32'd0);
      check("RST async running", 32'(running), 32'd0);
      repeat (3) @(negedge clk);
      check("RST no pause", 32'(cnt_pause - cp), 32'd0);
      reset = 1'b0;

      measure("base", DIV);
`ifdef BANNER_SPEED_EN
      send_byte(8'h2B);
      send_byte(8'h2B);
      measure("speed2", DIV >> 2);
      send_byte(8'h2B);
      send_byte(8'h2B);
      measure("speed3 sat", DIV >> 3);
      repeat (5) send_byte(8'h2D);
      measure("speed0 sat", DIV);
`else
      send_byte(8'h2B);
      measure("plus ignored", DIV);
      send_byte(8'h2D);
      measure("minus ignored", DIV);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/banner_scroll_ctrl.md
# banner_scroll_ctrl

Sequencer for the BCD banner shift register in the UART banner path. It decodes received UART bytes into a digit message buffer and scroll commands. It paces single-digit shift steps from a programmable tick, and reloads the message after it has scrolled fully out, so the banner wraps around. All shift-register control pins are driven only by this block.

## Interface
- `W`, 4: digit width in bits (BCD); only 4 is supported.
- `N`, 6: display digits; message buffer holds N digits.
- `DIV`, 50_000_000: clocks per scroll tick, ≥ 4.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `rx_data`  in  8  received UART byte.
- `rx_valid`  in  1  one-cycle strobe qualifying `rx_data`.
- `sr_data`  out  W*N  reload image for the shift register; equals the message buffer.
- `sr_write`  out  1  one-cycle load pulse to the shift register.
- `sr_start`  out  1  one-cycle shift-register start pulse.
- `sr_pause`  out  1  one-cycle shift-register pause pulse.
- `sr_set_left`, `sr_set_right`  out  1 each  one-cycle direction pulses.
- `running`  out  1  scrolling enabled.
- `dir_left`  out  1  current direction (1 = left).
- `step_cnt`  out  $clog2(N+1)  shifts since last reload.

## Operation
- Reset: all outputs 0; buffer 0; prescaler 0; FSM IDLE; `dir_left`=0 (right).
- Byte decode happens when `rx_valid`=1. Other byte values are ignored.
  - `0x30`–`0x39` (digit): buffer ← {buffer[W*N-W-1:0], byte[3:0]}. If not running, a write is scheduled.
  - `0x53` 'S': `running`←1.
  - `0x50` 'P': `running`←0.
  - `0x4C` 'L' / `0x52` 'R': direction pulse pending; `dir_left` updates; `step_cnt` forced to N, so the next tick reloads.
  - `0x43` 'C': buffer←0; write scheduled.
- FSM states:
  - IDLE: on a scheduled write, go to WRITE. Else, if a tick occurs and `running`=1: go to WRITE when `step_cnt`==N, otherwise go to ARM.
  - WRITE: `sr_write`=1 for one cycle; `step_cnt`←0; return to IDLE.
  - ARM: `sr_start`=1 for one cycle; go to STEP.
  - STEP: `sr_pause`=1 for one cycle; the register shifts exactly once on this edge; `step_cnt`++; return to IDLE.
- Direction pulse: issued from a pending flag in any cycle where `sr_write`=0. In a WRITE cycle it is deferred one cycle. 'L' and 'R' in consecutive bytes: the last one wins.
- A tick arriving while not in IDLE is dropped, not queued.
- 'P' mid-step: ARM/STEP still complete, so the register is left paused. `running` clears immediately.
- Digit during running: buffer updates immediately; it reaches the display at the next reload.
- Simultaneous scheduled write and tick: the write wins and the tick is dropped.

## Timing
- Prescaler counts 0..DIV-1 continuously; tick = terminal count (one cycle).
- Byte to state update: `running`, `dir_left`, buffer and `step_cnt` update on the edge sampling `rx_valid`.
- Scheduled write: `sr_write` asserts 2 cycles after the `rx_valid` edge (decode, then IDLE→WRITE).
- Direction pulse: 1 cycle after `rx_valid`, unless deferred.
- Step: tick edge → ARM (cycle +1, `sr_start`) → STEP (cycle +2, `sr_pause`). The shifted data is visible at cycle +3.
- Wrap period: N step ticks followed by 1 reload tick, i.e. (N+1)·DIV clocks per loop at a fixed speed.
- Reset mid-step: all pulses drop asynchronously; no partial pulse survives.

## Configuration
- `BANNER_SPEED_EN` defined:
  - Adds a 2-bit speed register, reset value 0.
  - `0x2B` '+' increments it, saturating at 3; `0x2D` '-' decrements it, saturating at 0.
  - Tick period = DIV >> speed.
  - A speed change restarts the prescaler at 0.
- `BANNER_SPEED_EN` undefined: '+' and '-' are ignored bytes; tick period is fixed at DIV.

## Test plan
- Reset, N=6, DIV=4: all outputs 0 and `dir_left`=0. Send bytes '1'..'6' → six `sr_write` pulses; final `sr_data`=0x123456.
- 'S', then run 28 clocks: exactly 6 start/pause pairs spaced 4 clocks apart, then one `sr_write` with `sr_data`=0x123456; `step_cnt` sequence 1..6, then 0.
- 'L' while running: `sr_set_left` pulses 1 cycle after the byte; the next tick produces `sr_write`, not `sr_start`; `dir_left`=1.
- 'P' strobed on the `sr_start` cycle: `sr_pause` still follows next cycle; no further `sr_start` over 40 clocks.
- 'C', then '7': `sr_write` with 0x000000, then `sr_write` with 0x000007. Assert `reset` during ARM: no `sr_pause` is emitted.
- `BANNER_SPEED_EN`, DIV=8: '+' twice → tick spacing 2 clocks; '+' twice more → spacing stays 1 (saturated); '-' ×5 → spacing 8.
